seq_mult: RTL

Parametrised sequential shift-add multiplier, the next generation of the fixed 32-bit unit. Adds configurable operand width, signed/unsigned selection per operation, and a start/busy/done handshake. Optionally adds early termination when the remaining multiplier bits are zero. It sits behind the execute stage as a multi-cycle functional unit and exposes its FSM state for debug.

---
 rtl/seq_mult_pkg.sv | 32 +++
 rtl/seq_mult_dp.sv | 96 +++++++++
 rtl/seq_mult.sv | 77 +++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the seq_mult shift-add multiplier: FSM state encoding,
// datapath operation select and a constant clog2 helper for counter sizing.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_mult_state_t;

    typedef enum logic [2:0] {
        OpHold  = 3'd0,
        OpLoad  = 3'd1,
        OpIter  = 3'd2,
        OpShift = 3'd3,
        OpFix   = 3'd4
    } seq_mult_op_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath for seq_mult: operand magnitudes, shift-add accumulator, sign fix-up.
// SEQ_MULT_EARLY_EXIT_EN adds the remaining-bits zero detect and the bulk shifter.
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  seq_mult_op_t       op,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               last,
    output logic               rest_zero,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;

    logic [WIDTH-1:0]   mcand_mag, mplier_mag;
    logic [WIDTH:0]     sum;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign mcand_mag  = (is_signed && multiplicand[WIDTH-1]) ? ~multiplicand + 1'b1
                                                             : multiplicand;
    assign mplier_mag = (is_signed && multiplier[WIDTH-1]) ? ~multiplier + 1'b1 : multiplier;

    assign sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0]   rest_mask;
    logic [2*WIDTH-1:0] shifted;

    // Bits [WIDTH-1-cnt:0] still hold the unconsumed multiplier bits.
    assign rest_mask = {WIDTH{1'b1}} >> cnt_q;
    assign rest_zero = ((p_q[WIDTH-1:0] & rest_mask) == '0);
    assign shifted   = p_q >> (CW'(WIDTH) - cnt_q);
`else
    assign rest_zero = 1'b0;
`endif

    always_comb begin
        mcand_d = mcand_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        case (op)
            OpLoad: begin
                mcand_d = mcand_mag;
                p_d     = {{WIDTH{1'b0}}, mplier_mag};
                cnt_d   = '0;
                sign_d  = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            end
            OpIter: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
`ifdef SEQ_MULT_EARLY_EXIT_EN
            OpShift: begin
                p_d = shifted;
            end
`endif
            OpFix: begin
                if (sign_q) begin
                    p_d = ~p_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier top: start/busy/done FSM driving seq_mult_dp.
// Define SEQ_MULT_EARLY_EXIT_EN to stop iterating once the remaining multiplier bits are zero.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         state
);

    seq_mult_state_t state_q, state_d;
    seq_mult_op_t    op;
    logic            last;
    logic            rest_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last || rest_zero) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        op   = OpHold;
        unique case (state_q)
            IDLE: if (start) op = OpLoad;
            RUN: begin
                busy = 1'b1;
                op   = rest_zero ? OpShift : OpIter;
            end
            FIX: begin
                busy = 1'b1;
                op   = OpFix;
            end
            DONE: done = 1'b1;
        endcase
    end

    seq_mult_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clock        (clock),
        .reset        (reset),
        .op           (op),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .last         (last),
        .rest_zero    (rest_zero),
        .p            (product)
    );

    assign state = state_q;

endmodule
